// File: rtl/aes_key_expand.sv
// AES-128 key-schedule sequencer: emits round keys 0..NR one per valid/ready handshake.
// Define AES_KEY_EXPAND_STORE_EN to add an 11-entry round-key store with a combinational read port.

module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);
  // FIPS-197 S-box, entry 0x00 in the leftmost byte
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data_o = SBOX[{data_i, 3'b000} +: 8];
endmodule

module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [0:3]   rk_index,
  output logic [0:127] round_key,
  output logic         done
`ifdef AES_KEY_EXPAND_STORE_EN
  ,
  input  logic [0:3]   rd_idx,
  output logic [0:127] rd_key
`endif
);

  localparam logic [0:3] LAST_IDX = 4'(NR);

  typedef enum logic {IDLE, GEN} state_t;

  state_t       state_q, state_d;
  logic [0:127] round_key_q, round_key_d;
  logic [0:3]   rk_index_q, rk_index_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;

  logic         handshake;
  logic [0:31]  sub_w, t_w, n0, n1, n2, n3;
  logic [0:127] next_key;
  logic [7:0]   rcon_next;

  // SubWord(RotWord(w3)): output byte g comes from w3 byte (g+1) mod 4
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .data_i (round_key_q[96 + 8*((g+1)%4) +: 8]),
      .data_o (sub_w[8*g +: 8])
    );
  end

  assign t_w       = sub_w ^ {rcon_q, 24'h000000};
  assign n0        = round_key_q[0:31]   ^ t_w;
  assign n1        = round_key_q[32:63]  ^ n0;
  assign n2        = round_key_q[64:95]  ^ n1;
  assign n3        = round_key_q[96:127] ^ n2;
  assign next_key  = {n0, n1, n2, n3};
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  assign handshake = (state_q == GEN) && rk_ready;

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    rk_index_d  = rk_index_q;
    rcon_d      = rcon_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = GEN;
          round_key_d = key_in;
          rk_index_d  = 4'd0;
          rcon_d      = 8'h01;
        end
      end
      GEN: begin
        if (rk_ready) begin
          if (rk_index_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            round_key_d = next_key;
            rk_index_d  = rk_index_q + 4'd1;
            rcon_d      = rcon_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      rk_index_q  <= 4'd0;
      rcon_q      <= 8'h01;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      rk_index_q  <= rk_index_d;
      rcon_q      <= rcon_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == GEN);
  assign rk_valid  = (state_q == GEN);
  assign rk_index  = rk_index_q;
  assign round_key = round_key_q;
  assign done      = done_q;

`ifdef AES_KEY_EXPAND_STORE_EN
  // Entries survive a new start and are overwritten as the new schedule is emitted
  logic [0:127] store_q [0:NR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) store_q[i] <= '0;
    end else if (handshake) begin
      store_q[rk_index_q] <= round_key_q;
    end
  end

  assign rd_key = (rd_idx <= LAST_IDX) ? store_q[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed self-checking bench for aes_key_expand using FIPS-197 and all-zero key schedules.
// Store checks compile only when AES_KEY_EXPAND_STORE_EN is defined.

module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [0:127] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [0:3]   rk_index;
  logic [0:127] round_key;
  logic         done;
`ifdef AES_KEY_EXPAND_STORE_EN
  logic [0:3]   rd_idx;
  logic [0:127] rd_key;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [0:127] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] ZERO_KEY = 128'h0;
  localparam logic [0:127] C_KEY    = 128'h000102030405060708090a0b0c0d0e0f;

  localparam logic [0:127] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  localparam logic [0:127] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [0:127] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_index  (rk_index),
    .round_key (round_key),
    .done      (done)
`ifdef AES_KEY_EXPAND_STORE_EN
    ,
    .rd_idx    (rd_idx),
    .rd_key    (rd_key)
`endif
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive all handshake inputs, then advance to the next falling edge
  task automatic applyStimulus(input logic s, input logic [0:127] k, input logic r);
    start    = s;
    key_in   = k;
    rk_ready = r;
    @(negedge clk);
  endtask

  task automatic checkRound(input string tag, input int idx, input logic [0:127] expKey);
    checkOutput($sformatf("%s_valid_%0d", tag, idx), rk_valid, 1);
    checkOutput($sformatf("%s_busy_%0d", tag, idx), busy, 1);
    checkOutput($sformatf("%s_index_%0d", tag, idx), rk_index, idx);
    checkOutput($sformatf("%s_key_%0d", tag, idx), round_key, expKey);
  endtask

  task automatic checkDone(input string tag, input logic [0:127] lastKey);
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_busy_low"}, busy, 0);
    checkOutput({tag, "_valid_low"}, rk_valid, 0);
    checkOutput({tag, "_key_kept"}, round_key, lastKey);
  endtask

  initial begin
    logic [15:0] pat;
    int expIdx;
    int cyc;

    rst_n    = 1'b0;
    start    = 1'b0;
    rk_ready = 1'b0;
    key_in   = '0;
`ifdef AES_KEY_EXPAND_STORE_EN
    rd_idx   = 4'd0;
`endif
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_valid", rk_valid, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_index", rk_index, 0);
    checkOutput("reset_key", round_key, 0);
    rst_n = 1'b1;

    // rk_ready while idle must not move anything
    applyStimulus(1'b0, FIPS_KEY, 1'b1);
    applyStimulus(1'b0, FIPS_KEY, 1'b1);
    checkOutput("idle_ready_valid", rk_valid, 0);
    checkOutput("idle_ready_index", rk_index, 0);
    checkOutput("idle_ready_key", round_key, 0);

    // FIPS-197 schedule, stall-free
    applyStimulus(1'b1, FIPS_KEY, 1'b1);
    start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      checkRound("fips", i, FIPS_RK[i]);
      checkOutput($sformatf("fips_nodone_%0d", i), done, 0);
      @(negedge clk);
    end
    checkDone("fips", FIPS_RK[10]);
    @(negedge clk);
    checkOutput("fips_done_clear", done, 0);
    checkOutput("fips_index_kept", rk_index, 10);

    // All-zero key
    applyStimulus(1'b1, ZERO_KEY, 1'b1);
    start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      checkOutput($sformatf("zero_index_%0d", i), rk_index, i);
      if (i == 1)  checkOutput("zero_key_1", round_key, ZERO_RK1);
      if (i == 10) checkOutput("zero_key_10", round_key, ZERO_RK10);
      @(negedge clk);
    end
    checkDone("zero", ZERO_RK10);
    @(negedge clk);

    // Backpressure: keys hold while rk_ready=0 and none is skipped or repeated
    pat    = 16'b1001_1010_0011_0101;
    expIdx = 0;
    cyc    = 0;
    applyStimulus(1'b1, FIPS_KEY, 1'b0);
    start = 1'b0;
    while (expIdx <= 10 && cyc < 200) begin
      checkRound("bp", expIdx, FIPS_RK[expIdx]);
      rk_ready = pat[cyc % 16];
      @(negedge clk);
      if (rk_ready) expIdx++;
      cyc++;
    end
    checkOutput("bp_complete", expIdx, 11);
    checkDone("bp", FIPS_RK[10]);
    @(negedge clk);

    // start mid-run and on the final handshake is ignored; start during done is accepted
    applyStimulus(1'b1, FIPS_KEY, 1'b1);
    for (int i = 0; i <= 10; i++) begin
      checkRound("ign", i, FIPS_RK[i]);
      start  = (i == 4) || (i == 10);
      key_in = (i >= 4) ? ZERO_KEY : FIPS_KEY;
      @(negedge clk);
    end
    checkDone("ign", FIPS_RK[10]);
    applyStimulus(1'b1, C_KEY, 1'b1);
    checkRound("restart", 0, C_KEY);
    checkOutput("restart_done_clear", done, 0);
    start = 1'b0;

    // Reset at round 6 aborts immediately with no done pulse
    for (int i = 0; i < 6; i++) @(negedge clk);
    checkOutput("abort_pre_index", rk_index, 6);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_valid", rk_valid, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_index", rk_index, 0);
    checkOutput("abort_key", round_key, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_done_later", done, 0);
    rst_n = 1'b1;

    // Fresh run after reset; key_in changes after acceptance must not matter
    applyStimulus(1'b1, FIPS_KEY, 1'b1);
    start  = 1'b0;
    key_in = ZERO_KEY;
    for (int i = 0; i <= 10; i++) begin
      checkRound("post", i, FIPS_RK[i]);
      @(negedge clk);
    end
    checkDone("post", FIPS_RK[10]);
    @(negedge clk);

`ifdef AES_KEY_EXPAND_STORE_EN
    rd_idx = 4'd1;
    #1 checkOutput("store_rd1", rd_key, FIPS_RK[1]);
    rd_idx = 4'd10;
    #1 checkOutput("store_rd10", rd_key, FIPS_RK[10]);
    rd_idx = 4'd0;
    #1 checkOutput("store_rd0", rd_key, FIPS_RK[0]);
    rd_idx = 4'd15;
    #1 checkOutput("store_rd15", rd_key, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
